// File: rtl/cordic_pkg.sv
// cordic_pkg: mode encodings, fixed-point format and job-controller state encoding
package cordic_pkg;
    localparam logic [1:0] LINEAR        = 2'b00;
    localparam logic [1:0] CIRCULAR      = 2'b01;
    localparam logic [1:0] ILLEGAL_COORD = 2'b10;
    localparam logic [1:0] HYPERBOLIC    = 2'b11;
    localparam logic       ROTATION      = 1'b0;
    localparam logic       VECTORING     = 1'b1;
    localparam int         FRAC_BITS     = 16;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;
endpackage

// File: rtl/cordic_job_ctrl_if.sv
// cordic_job_ctrl_if: request, core and response channels of the cordic job controller
interface cordic_job_ctrl_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 req_valid, req_ready, req_mode_op;
    logic [1:0]           req_mode_coord;
    logic [WIDTH-1:0]     req_x, req_y, req_z;
    logic                 cor_enable, cor_mode_op, cor_valid;
    logic [1:0]           cor_mode_coord;
    logic [WIDTH-1:0]     cor_x_in, cor_y_in, cor_z_in;
    logic [WIDTH-1:0]     cor_x_out, cor_y_out, cor_z_out;
    logic                 rsp_valid, rsp_ready, rsp_error, rsp_timeout;
    logic [WIDTH-1:0]     rsp_x, rsp_y, rsp_z;
    logic [CNT_WIDTH-1:0] jobs_done;
    modport master (
        input  req_valid, req_mode_op, req_mode_coord, req_x, req_y, req_z,
        input  cor_x_out, cor_y_out, cor_z_out, cor_valid, rsp_ready,
        output req_ready, cor_enable, cor_mode_op, cor_mode_coord, cor_x_in, cor_y_in, cor_z_in,
        output rsp_valid, rsp_x, rsp_y, rsp_z, rsp_error, rsp_timeout, jobs_done
    );
    modport slave (
        output req_valid, req_mode_op, req_mode_coord, req_x, req_y, req_z,
        output cor_x_out, cor_y_out, cor_z_out, cor_valid, rsp_ready,
        input  req_ready, cor_enable, cor_mode_op, cor_mode_coord, cor_x_in, cor_y_in, cor_z_in,
        input  rsp_valid, rsp_x, rsp_y, rsp_z, rsp_error, rsp_timeout, jobs_done
    );
endinterface

// File: rtl/cordic_job_ctrl.sv
// cordic_job_ctrl: launches one cordic job at a time, captures its result, and guards
// against illegal modes and a core that never completes
module cordic_job_ctrl
    import cordic_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic clk,
    input  logic rst,
    cordic_job_ctrl_if.master bus
);
    localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
    state_t               state_q, state_d;
    logic                 op_q, op_d, err_q, err_d, tmo_q, tmo_d, valid_q, valid_d;
    logic [1:0]           coord_q, coord_d;
    logic [WIDTH-1:0]     x_q, x_d, y_q, y_d, z_q, z_d;
    logic [WIDTH-1:0]     rx_q, rx_d, ry_q, ry_d, rz_q, rz_d;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] jobs_q, jobs_d;
    logic                 done;
    // only a rising edge of cor_valid completes, so a level left high by the last job is ignored
    assign done    = bus.cor_valid && !valid_q;
    assign valid_d = bus.cor_valid;
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        coord_d = coord_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        rz_d    = rz_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        jobs_d  = jobs_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                op_d    = bus.req_mode_op;
                coord_d = bus.req_mode_coord;
                x_d     = bus.req_x;
                y_d     = bus.req_y;
                z_d     = bus.req_z;
                if (bus.req_mode_coord == ILLEGAL_COORD) begin
                    {rx_d, ry_d, rz_d} = '0;
                    err_d   = 1'b1;
                    state_d = HOLD;
                end else state_d = LAUNCH;
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (done) begin
                {rx_d, ry_d, rz_d} = {bus.cor_x_out, bus.cor_y_out, bus.cor_z_out};
                state_d = HOLD;
            end else if (cnt_q == LAST) begin
                {rx_d, ry_d, rz_d} = '0;
                tmo_d   = 1'b1;
                state_d = HOLD;
            end else cnt_d = cnt_q + 1'b1;
            HOLD: if (bus.rsp_ready) begin
                jobs_d  = (err_q || tmo_q) ? jobs_q : jobs_q + 1'b1;
                err_d   = 1'b0;
                tmo_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            {op_q, coord_q, x_q, y_q, z_q} <= '0;
            {rx_q, ry_q, rz_q} <= '0;
            {err_q, tmo_q, valid_q} <= '0;
            cnt_q   <= '0;
            jobs_q  <= '0;
        end else begin
            state_q <= state_d;
            {op_q, coord_q, x_q, y_q, z_q} <= {op_d, coord_d, x_d, y_d, z_d};
            {rx_q, ry_q, rz_q} <= {rx_d, ry_d, rz_d};
            {err_q, tmo_q, valid_q} <= {err_d, tmo_d, valid_d};
            cnt_q   <= cnt_d;
            jobs_q  <= jobs_d;
        end
    end
    assign bus.req_ready      = state_q == IDLE;
    assign bus.cor_enable     = state_q == LAUNCH;
    assign bus.rsp_valid      = state_q == HOLD;
    assign bus.cor_mode_op    = op_q;
    assign bus.cor_mode_coord = coord_q;
    assign bus.cor_x_in       = x_q;
    assign bus.cor_y_in       = y_q;
    assign bus.cor_z_in       = z_q;
    assign bus.rsp_x          = rx_q;
    assign bus.rsp_y          = ry_q;
    assign bus.rsp_z          = rz_q;
    assign bus.rsp_error      = err_q;
    assign bus.rsp_timeout    = tmo_q;
    assign bus.jobs_done      = jobs_q;
endmodule

// File: tb/tb_cordic_job_ctrl.sv
// tb_cordic_job_ctrl: plays client, cordic core and consumer around the controller and
// checks every response against a job-level model of the expected outcome
module tb_cordic_job_ctrl;
    import cordic_pkg::*;
    localparam int W   = 32;
    localparam int TMO = 8;
    localparam int CW  = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          exp_jobs = 0;
    logic [95:0] got;
    cordic_job_ctrl_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();
    cordic_job_ctrl #(.WIDTH(W), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // ideal core behaviour: exact linear math, an arbitrary mix for the other modes
    function automatic logic [95:0] core_fn(input logic op, input logic [1:0] coord,
                                            input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        longint sx, sy, sz;
        logic [31:0] ny, nz;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sz = longint'($signed(z));
        if (coord == LINEAR && op == ROTATION) begin
            ny = 32'(sy + ((sx * sz) >>> FRAC_BITS));
            nz = '0;
        end else if (coord == LINEAR && sx != 0) begin
            ny = '0;
            nz = 32'(sz + (sy <<< FRAC_BITS) / sx);
        end else begin
            ny = y + z;
            nz = z ^ x;
        end
        return {x, ny, nz};
    endfunction
    // lat: sample index after the launch at which the core answers (0 = never);
    // stale: cor_valid is already high and must dip before the answer; keep: leave it high after
    task automatic do_job(input logic op, input logic [1:0] coord, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] z, input int lat, input bit stale, input bit keep, input int stall,
                          output logic [95:0] rsp);
        logic [95:0] r, exp_rsp, held;
        bit illegal, tmo, ok;
        int n, exp_n;
        illegal = coord == ILLEGAL_COORD;
        tmo     = !illegal && lat == 0;
        r       = core_fn(op, coord, x, y, z);
        exp_rsp = (illegal || tmo) ? '0 : r;
        exp_n   = tmo ? TMO + 1 : stale ? lat + 2 : lat + 1;
        {bus.cor_x_out, bus.cor_y_out, bus.cor_z_out} = {$urandom, $urandom, $urandom};
        chk("idle_ready", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        {bus.req_mode_op, bus.req_mode_coord, bus.req_x, bus.req_y, bus.req_z} = {op, coord, x, y, z};
        @(negedge clk);
        bus.req_valid = 1'b0;
        {bus.req_mode_op, bus.req_mode_coord, bus.req_x, bus.req_y, bus.req_z} = {~op, ~coord, $urandom, $urandom, $urandom};
        if (illegal) chk("illegal_no_launch", {bus.cor_enable, bus.rsp_valid}, 2'b01);
        else begin
            chk("launch", {bus.cor_enable, bus.rsp_valid}, 2'b10);
            n  = 0;
            ok = 1'b1;
            while (!bus.rsp_valid && n < 40) begin
                if ((n > 0 && bus.cor_enable) ||
                    {bus.cor_mode_op, bus.cor_mode_coord, bus.cor_x_in, bus.cor_y_in, bus.cor_z_in} !== {op, coord, x, y, z})
                    ok = 1'b0;
                if (!tmo && n == lat) begin
                    bus.cor_valid = !stale;
                    if (!stale) {bus.cor_x_out, bus.cor_y_out, bus.cor_z_out} = r;
                end
                if (!tmo && stale && n == lat + 1) begin
                    bus.cor_valid = 1'b1;
                    {bus.cor_x_out, bus.cor_y_out, bus.cor_z_out} = r;
                end
                @(negedge clk);
                n++;
            end
            if (!tmo) bus.cor_valid = keep;
            chk("latency", n, exp_n);
            chk("one_pulse_stable_ops", ok, 1'b1);
        end
        held = {bus.rsp_x, bus.rsp_y, bus.rsp_z};
        ok   = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if ({bus.rsp_x, bus.rsp_y, bus.rsp_z} !== held || !bus.rsp_valid || bus.req_ready) ok = 1'b0;
        end
        if (stall > 0) chk("backpressure_hold", ok, 1'b1);
        chk("rsp_data", {bus.rsp_x, bus.rsp_y, bus.rsp_z}, exp_rsp);
        chk("rsp_flags", {bus.rsp_valid, bus.rsp_error, bus.rsp_timeout}, {1'b1, illegal, tmo});
        rsp = {bus.rsp_x, bus.rsp_y, bus.rsp_z};
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        if (!illegal && !tmo) exp_jobs = (exp_jobs + 1) % (1 << CW);
        chk("jobs_done", bus.jobs_done, exp_jobs);
        chk("after_handshake", {bus.rsp_valid, bus.rsp_error, bus.rsp_timeout, bus.req_ready}, 4'b0001);
    endtask
    initial begin
        logic       rop;
        logic [1:0] rco;
        int         rl, rs;
        bit         ok;
        {bus.req_valid, bus.req_mode_op, bus.req_mode_coord, bus.req_x, bus.req_y, bus.req_z} = '0;
        {bus.cor_x_out, bus.cor_y_out, bus.cor_z_out, bus.cor_valid, bus.rsp_ready} = '0;
        repeat (2) @(negedge clk);
        chk("reset_core_side", {bus.req_ready, bus.cor_enable, bus.cor_mode_op, bus.cor_mode_coord,
            bus.cor_x_in, bus.cor_y_in, bus.cor_z_in}, {1'b1, 100'b0});
        chk("reset_rsp_side", {bus.rsp_valid, bus.rsp_x, bus.rsp_y, bus.rsp_z, bus.rsp_error,
            bus.rsp_timeout, bus.jobs_done}, 128'd0);
        rst = 1'b1;
        @(negedge clk);
        do_job(ROTATION, LINEAR, 32'h0005_0000, 32'h0, 32'h0001_8000, 3, 0, 0, 0, got);
        chk("lin_rot_x", got[95:64], 32'h0005_0000);
        chk("lin_rot_y", got[63:32], 32'h0007_8000);
        chk("lin_rot_jobs", bus.jobs_done, 4'd1);
        do_job(VECTORING, LINEAR, 32'h0002_0000, 32'h0003_0000, 32'h0, 5, 0, 0, 0, got);
        chk("lin_vec_yz", got[63:0], {32'h0, 32'h0001_8000});
        do_job(ROTATION, ILLEGAL_COORD, $urandom, $urandom, $urandom, 2, 0, 0, 0, got);
        do_job(VECTORING, CIRCULAR, $urandom, $urandom, $urandom, 0, 0, 0, 0, got);
        do_job(ROTATION, HYPERBOLIC, $urandom, $urandom, $urandom, TMO, 0, 0, 0, got);
        do_job(ROTATION, CIRCULAR, $urandom, $urandom, $urandom, 2, 0, 1, 10, got);
        do_job(VECTORING, CIRCULAR, $urandom, $urandom, $urandom, 4, 1, 0, 0, got);
        // abandon a job mid-WAIT; a late core answer must not surface
        bus.req_valid = 1'b1;
        {bus.req_mode_op, bus.req_mode_coord, bus.req_x, bus.req_y, bus.req_z} = {ROTATION, CIRCULAR, 32'h1234, 32'h5678, 32'h9abc};
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_jobs = 0;
        chk("midjob_reset_core_side", {bus.req_ready, bus.cor_enable, bus.cor_mode_op, bus.cor_mode_coord,
            bus.cor_x_in, bus.cor_y_in, bus.cor_z_in}, {1'b1, 100'b0});
        chk("midjob_reset_rsp_side", {bus.rsp_valid, bus.rsp_x, bus.rsp_y, bus.rsp_z, bus.rsp_error,
            bus.rsp_timeout, bus.jobs_done}, 128'd0);
        bus.cor_valid = 1'b1;
        @(negedge clk);
        bus.cor_valid = 1'b0;
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid || !bus.req_ready) ok = 1'b0;
        end
        chk("late_valid_ignored", ok, 1'b1);
        do_job(ROTATION, LINEAR, 32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 1, 0, 0, 1, got);
        for (int i = 0; i < 40; i++) begin
            rop = 1'($urandom);
            rco = 2'($urandom);
            rl  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TMO);
            rs  = $urandom_range(0, 3);
            do_job(rop, rco, $urandom, $urandom, $urandom, rl, 0, 0, rs, got);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cordic_job_ctrl.md
Name: cordic_job_ctrl

Overview:
Hardware initiator for the `cordic` core. It accepts one job at a time from an upstream client over a valid/ready request channel. For each job it drives the core's `enable`/mode/operand inputs, waits for the core's `valid`, captures `x_out`/`y_out`/`z_out`, and presents them on a valid/ready response channel. It replaces bench-driven stimulus when the core is embedded in a datapath. It also adds protection against illegal modes and timeouts.

Parameters:
- WIDTH, 32, operand/result width (Q16.16 at default)
- TIMEOUT_CYCLES, 64, max cycles spent in WAIT before aborting a job
- CNT_WIDTH, 16, width of the completed-job counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- req_valid  in  1  job offered
- req_ready  out  1  controller can accept a job
- req_mode_op  in  1  0 rotation, 1 vectoring
- req_mode_coord  in  2  01 circular, 00 linear, 11 hyperbolic, 10 illegal
- req_x, req_y, req_z  in  WIDTH each  signed operands
- cor_enable  out  1  one-cycle start pulse to core
- cor_mode_op  out  1  to core
- cor_mode_coord  out  2  to core
- cor_x_in, cor_y_in, cor_z_in  out  WIDTH each  to core
- cor_x_out, cor_y_out, cor_z_out  in  WIDTH each  from core
- cor_valid  in  1  core result valid (pulse or level)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_x, rsp_y, rsp_z  out  WIDTH each  captured results
- rsp_error  out  1  illegal mode; no core launch
- rsp_timeout  out  1  core did not complete in time
- jobs_done  out  CNT_WIDTH  count of successful responses delivered

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE. All outputs are 0 except req_ready=1. Also clears valid_q and the timeout counter. Reset mid-job abandons the job; a later core valid is ignored.
- FSM states: IDLE, LAUNCH, WAIT, HOLD.
- IDLE: req_ready=1. On req_valid&&req_ready, register op/coord/x/y/z.
  - If coord==2'b10: go to HOLD with rsp_error=1 and rsp_x/y/z=0. The core is never launched.
  - Otherwise go to LAUNCH.
- LAUNCH: exactly one cycle. cor_enable=1; cor_* inputs show the registered values. Next state WAIT, with timeout counter=0.
- WAIT: cor_enable=0. cor_mode/operand outputs stay stable for the whole job.
  - valid_q is cor_valid delayed one cycle. Completion is detected only when cor_valid==1 && valid_q==0, so a stale level-high valid from a previous job is never accepted.
  - On completion: capture cor_x/y/z_out into rsp_x/y/z and go to HOLD.
  - Timeout counter increments each WAIT cycle. If it reaches TIMEOUT_CYCLES-1 without completion, go to HOLD with rsp_timeout=1 and rsp_x/y/z=0.
  - If completion and timeout occur in the same cycle, completion wins.
- HOLD: rsp_valid=1 and rsp_* stay stable until rsp_valid&&rsp_ready.
  - On handshake: clear rsp_valid/error/timeout and go to IDLE.
  - jobs_done increments only on the handshake of a non-error, non-timeout response. It wraps at 2^CNT_WIDTH-1 to 0.
- req_ready=0 in every state except IDLE. No pipelining: one job in flight.
- Minimum latency, request accept to rsp_valid: 2 cycles plus the core latency after the enable pulse.
- The controller does no arithmetic; widths pass through unchanged.

Decomposition:
- Shared package cordic_pkg holds:
  - mode constants CIRCULAR=2'b01, LINEAR=2'b00, HYPERBOLIC=2'b11, ROTATION=1'b0, VECTORING=1'b1
  - ILLEGAL_COORD=2'b10
  - FRAC_BITS=16
  - FSM state encoding
- No sub-module; the FSM, capture registers and counters form one module.

Test Plan:
- Linear rotation: x=0x00050000 (5.0), y=0, z=0x00018000 (1.5) → one cor_enable pulse; rsp_y≈0x00078000 (7.5, ±4 LSB); rsp_x=0x00050000; jobs_done=1.
- Linear vectoring: x=0x00020000 (2.0), y=0x00030000 (3.0), z=0 → rsp_z≈0x00018000 (1.5, ±4 LSB); rsp_y≈0.
- Illegal mode: coord=2'b10 → cor_enable stays 0; rsp_valid within 2 cycles; rsp_error=1; rsp data=0; jobs_done unchanged.
- Timeout (stub core, cor_valid tied 0; TIMEOUT_CYCLES=8) → rsp_timeout=1 exactly 8 WAIT cycles after LAUNCH; jobs_done unchanged.
- Backpressure plus stale valid:
  - Hold rsp_ready=0 for 10 cycles → rsp data stable and req_ready=0 throughout.
  - Stub core holds cor_valid=1 continuously from a previous job → no completion until valid goes low then high.
- Reset mid-WAIT (rst=0 for 1 cycle) → all outputs at reset values next cycle. A later core valid produces no rsp_valid; a new job then completes normally.
